gol_matrix_scan: RTL and testbench
==================================

Name: gol_matrix_scan

Overview:
- Display-side consumer of the 64-bit Game-of-Life grid produced by the generator.
- Accepts a grid over a valid/ready handshake into a pending buffer and swaps it into an active buffer only at frame boundaries, so there is no tearing.
- Time-multiplexes the active grid onto an 8x8 LED matrix, one row at a time, with per-row blanking to suppress ghosting.

Parameters:
- ROW_CYCLES, 1000: clock cycles spent on each row, blanking included; legal range ≥ 2.
- BLANK_CYCLES, 50: leading cycles of each row with outputs forced off; must be < ROW_CYCLES.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- start  in  1  reset, synchronous, active-high.
- grid_in  in  64  grid word; bit 63 = row 0 col 7, bit 0 = row 7 col 0.
- grid_valid  in  1  grid_in is valid this cycle.
- grid_ready  out  1  block can accept a grid this cycle.
- row_sel  out  8  one-hot row enable; bit r drives row r.
- col_out  out  8  column data for the selected row; bit c = column c.
- frame_done  out  1  one-cycle pulse on the last cycle of row 7.
- scanning  out  1  high whenever the active buffer holds a displayed grid.

Behaviour:
- Clock and reset: one clock (clk); reset (start) is synchronous and active-high.
- Reset, on a clk edge with start=1:
  - state=IDLE; pending_full=0; active and pending buffers=0; row and cycle counters=0.
  - Outputs: row_sel=0, col_out=0, frame_done=0, scanning=0, grid_ready=1 from the next cycle.
  - Reset mid-scan aborts immediately; the next displayed grid must be newly accepted.
- Handshake:
  - grid_ready = !pending_full.
  - Transfer occurs when grid_valid && grid_ready; pending <= grid_in and pending_full <= 1 at that edge.
  - grid_in is ignored when no transfer occurs.
- States:
  - IDLE: outputs off. If pending_full is 1 (registered value): active <= pending, pending_full <= 0, row <= 0, cyc <= 0, go to SCAN.
  - SCAN:
    - cyc counts 0..ROW_CYCLES-1, then wraps to 0 and row increments; row wraps 7 -> 0.
    - Boundary cycle is row=7, cyc=ROW_CYCLES-1: frame_done=1.
    - At that edge, if pending_full=1: active <= pending and pending_full <= 0. Otherwise active is held, so the same grid repeats indefinitely.
    - SCAN never returns to IDLE except via reset.
- Outputs, combinational from registered state:
  - Blank window (cyc < BLANK_CYCLES): row_sel=0, col_out=0.
  - Drive window (cyc ≥ BLANK_CYCLES): row_sel = 1<<row, col_out = active[63-8*row -: 8], i.e. row 0 = active[63:56].
  - scanning = (state==SCAN).
- Latency: a transfer at edge N sets pending at N; IDLE swaps at N+1. Row 0 drive begins BLANK_CYCLES cycles after edge N+1.
- Simultaneous events:
  - A transfer on the boundary cycle while pending_full=0 loads pending only. That grid is displayed at the next boundary, not the current one.
  - Swap and transfer can never coincide, since ready=0 while pending is full.
- Counter widths: cyc is $clog2(ROW_CYCLES) bits; row is 3 bits. No overflow beyond wrap.

Test Plan:
- Reset: hold start=1 for 3 cycles mid-scan -> next cycle row_sel=0, col_out=0, scanning=0, frame_done=0, grid_ready=1; no output until a new transfer.
- Glider, with ROW_CYCLES=4, BLANK_CYCLES=1:
  - Stimulus: transfer 64'h4020_E000_0000_0000.
  - Expected: row 0 drive shows row_sel=8'h01, col_out=8'h40; row 1 shows 8'h02/8'h20; row 2 shows 8'h04/8'hE0; rows 3-7 show col_out=8'h00.
  - Each row is blank for 1 cycle and driven for 3; frame_done pulses every 32 cycles.
- Backpressure:
  - Stimulus: during SCAN, offer grid A (accepted), then hold grid_valid with grid B.
  - Expected: grid_ready=0 until the boundary cycle's edge; B is accepted the cycle after; A is displayed starting at row 0 of the next frame.
- No tearing: send 64'hFFFF_FFFF_FFFF_FFFF while row 3 of an all-zero frame is showing -> rows 3-7 stay col_out=8'h00 this frame; all rows show 8'hFF next frame.
- Boundary transfer: assert a transfer exactly on the frame_done cycle with pending empty -> the following frame still shows the old grid; the new grid appears one frame later.
- Hold: no new grids for 5 frames -> the identical row/col sequence repeats, with exactly 5 frame_done pulses and grid_ready=1 throughout.

Source files
------------

// File: rtl/gol_matrix_scan.sv
// Display-side scanner for the 8x8 Game-of-Life grid: double-buffered grid intake
// over valid/ready, tear-free swap at frame boundaries, row-multiplexed LED drive.
module gol_matrix_scan #(
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk,
  input  logic        start,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ready,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_out,
  output logic        frame_done,
  output logic        scanning
);

  localparam int CW = $clog2(ROW_CYCLES);
  localparam logic [CW-1:0] CYC_LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic          pending_full;
  logic [63:0]   pending;
  logic [63:0]   active;
  logic [2:0]    row;
  logic [CW-1:0] cyc;

  logic          row_end;
  logic          frame_end;
  logic          drive;

  always_comb begin
    row_end   = (state == SCAN) && (cyc == CYC_LAST);
    frame_end = row_end && (row == 3'd7);
    drive     = (state == SCAN) && (cyc >= CYC_BLANK);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state        <= IDLE;
      pending_full <= 1'b0;
      pending      <= '0;
      active       <= '0;
      row          <= '0;
      cyc          <= '0;
    end else begin
      // Intake only while pending is empty, so it never collides with a swap below.
      if (grid_valid && !pending_full) begin
        pending      <= grid_in;
        pending_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
            row          <= '0;
            cyc          <= '0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (row_end) begin
            cyc <= '0;
            row <= row + 3'd1;
            if (frame_end && pending_full) begin
              active       <= pending;
              pending_full <= 1'b0;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    grid_ready = !pending_full;
    scanning   = (state == SCAN);
    frame_done = frame_end;
    row_sel    = '0;
    col_out    = '0;
    if (drive) begin
      row_sel = 8'd1 << row;
      // Row r occupies bits [63-8r -: 8]; ~row == 7-row gives the byte base.
      col_out = active[{~row, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Self-checking bench for gol_matrix_scan with short rows (4 cycles, 1 blank):
// a per-cycle frame monitor backed by a queue of expected frame grids, plus directed sequences.
module tb_gol_matrix_scan;

  localparam int RC    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * RC;
  localparam int LIMIT = 200;

  logic        clk;
  logic        start;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_out;
  logic        frame_done;
  logic        scanning;

  gol_matrix_scan #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .start      (start),
    .grid_in    (grid_in),
    .grid_valid (grid_valid),
    .grid_ready (grid_ready),
    .row_sel    (row_sel),
    .col_out    (col_out),
    .frame_done (frame_done),
    .scanning   (scanning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: grid expected from a given frame index onward.
  typedef struct {
    int          frame;
    logic [63:0] grid;
  } sb_t;
  sb_t sbq[$];

  int          fidx = 0;
  int          pos  = 0;
  logic [63:0] cur  = '0;

  task automatic expect_frame(input int f, input logic [63:0] g);
    sb_t e;
    e.frame = f;
    e.grid  = g;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    int r;
    int c;
    logic [7:0] ers;
    logic [7:0] ecol;
    logic [63:0] sh;
    if (start) begin
      sbq.delete();
      fidx = 0;
      pos  = 0;
      cur  = '0;
    end else if (!scanning) begin
      chk("idle_row_sel", 32'(row_sel), 32'h0);
      chk("idle_col_out", 32'(col_out), 32'h0);
      chk("idle_frame_done", 32'(frame_done), 32'h0);
    end else begin
      r = (pos / RC) % 8;
      c = pos % RC;
      if (pos % FRAME == 0) begin
        while (sbq.size() > 0 && sbq[0].frame <= fidx) begin
          sb_t e;
          e   = sbq.pop_front();
          cur = e.grid;
        end
      end
      sh   = cur >> (8 * (7 - r));
      ers  = (c >= BC) ? 8'(1 << r) : 8'h00;
      ecol = (c >= BC) ? sh[7:0] : 8'h00;
      chk("mon_row_sel", 32'(row_sel), 32'(ers));
      chk("mon_col_out", 32'(col_out), 32'(ecol));
      chk("mon_frame_done", 32'(frame_done), 32'((r == 7) && (c == RC - 1)));
      if (r == 7 && c == RC - 1) fidx++;
      pos++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] g);
    int n;
    n = 0;
    grid_valid = 1'b1;
    grid_in    = g;
    while (!grid_ready && n < LIMIT) begin
      tick();
      n++;
    end
    chk("send_timeout", 32'(n < LIMIT), 32'h1);
    tick();
    grid_valid = 1'b0;
    grid_in    = '0;
  endtask

  task automatic wait_rs(input logic [7:0] v, input string name);
    int n;
    n = 0;
    while (row_sel !== v && n < LIMIT) begin
      tick();
      n++;
    end
    chk(name, 32'(n < LIMIT), 32'h1);
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    chk(name, 32'(n < LIMIT), 32'h1);
  endtask

  task automatic do_reset();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("rst_row_sel", 32'(row_sel), 32'h0);
    chk("rst_col_out", 32'(col_out), 32'h0);
    chk("rst_scanning", 32'(scanning), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_grid_ready", 32'(grid_ready), 32'h1);
    repeat (5) begin
      tick();
      chk("rst_stays_idle", 32'(scanning), 32'h0);
    end
  endtask

  typedef struct {
    logic [7:0] rs;
    logic [7:0] col;
  } row_vec_t;
  row_vec_t gtab[8];

  localparam logic [63:0] GLIDER = 64'h4020_E000_0000_0000;
  localparam logic [63:0] GX     = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] GA     = 64'hA55A_0F0F_F0F0_1234;
  localparam logic [63:0] GB     = 64'h3C3C_8181_7E7E_0001;
  localparam logic [63:0] GFULL  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int f;
    int n;
    int fd_cnt;
    logic prev_fd;
    logic [15:0] seq[FRAME];

    gtab[0] = '{8'h01, 8'h40};
    gtab[1] = '{8'h02, 8'h20};
    gtab[2] = '{8'h04, 8'hE0};
    gtab[3] = '{8'h08, 8'h00};
    gtab[4] = '{8'h10, 8'h00};
    gtab[5] = '{8'h20, 8'h00};
    gtab[6] = '{8'h40, 8'h00};
    gtab[7] = '{8'h80, 8'h00};

    start      = 1'b1;
    grid_valid = 1'b0;
    grid_in    = '0;
    do_reset();

    // Glider: one frame walked row by row against the table.
    expect_frame(0, GLIDER);
    send(GLIDER);
    tick();
    for (int r = 0; r < 8; r++) begin
      chk("glider_blank_rs", 32'(row_sel), 32'h0);
      chk("glider_blank_col", 32'(col_out), 32'h0);
      for (int k = 1; k < RC; k++) begin
        tick();
        chk("glider_row_sel", 32'(row_sel), 32'(gtab[r].rs));
        chk("glider_col_out", 32'(col_out), 32'(gtab[r].col));
        chk("glider_frame_done", 32'(frame_done), 32'((r == 7) && (k == RC - 1)));
      end
      tick();
    end

    // Boundary transfer: lands in pending only, shown one frame later.
    wait_fd("bnd_wait_fd");
    chk("bnd_ready", 32'(grid_ready), 32'h1);
    expect_frame(fidx + 2, GX);
    send(GX);
    wait_rs(8'h01, "bnd_wait_row0");
    chk("bnd_old_grid_row0", 32'(col_out), 32'h40);
    wait_fd("bnd_wait_fd2");
    tick();
    wait_rs(8'h01, "bnd_wait_row0_new");
    chk("bnd_new_grid_row0", 32'(col_out), 32'h01);

    // Backpressure: A fills pending, B waits for the boundary swap.
    wait_rs(8'h04, "bp_wait_row2");
    f = fidx;
    expect_frame(f + 1, GA);
    expect_frame(f + 2, GB);
    send(GA);
    grid_valid = 1'b1;
    grid_in    = GB;
    n = 0;
    prev_fd = 1'b0;
    while (!grid_ready && n < LIMIT) begin
      prev_fd = frame_done;
      tick();
      n++;
    end
    chk("bp_ready_low_cycles", 32'(n), 32'd22);
    chk("bp_ready_after_boundary", 32'(prev_fd), 32'h1);
    tick();
    grid_valid = 1'b0;
    grid_in    = '0;
    chk("bp_b_accepted", 32'(grid_ready), 32'h0);
    chk("bp_a_row0_rs", 32'(row_sel), 32'h01);
    chk("bp_a_row0_col", 32'(col_out), 32'hA5);

    // Hold: B repeats unchanged for five frames.
    wait_fd("hold_wait_fd");
    tick();
    fd_cnt = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      chk("hold_grid_ready", 32'(grid_ready), 32'h1);
      if (frame_done) fd_cnt++;
      if (i < FRAME) seq[i] = {row_sel, col_out};
      else chk("hold_repeat", 32'({row_sel, col_out}), 32'(seq[i % FRAME]));
      tick();
    end
    chk("hold_fd_count", 32'(fd_cnt), 32'd5);

    // Reset mid-scan aborts display.
    do_reset();

    // No tearing: full grid sent during row 3 of an all-zero frame.
    expect_frame(0, 64'h0);
    send(64'h0);
    wait_rs(8'h08, "tear_wait_row3");
    expect_frame(fidx + 1, GFULL);
    send(GFULL);
    n = 0;
    while (n < LIMIT) begin
      chk("tear_cur_frame_zero", 32'(col_out), 32'h0);
      if (frame_done) break;
      tick();
      n++;
    end
    chk("tear_wait_fd", 32'(n < LIMIT), 32'h1);
    tick();
    for (int i = 0; i < FRAME; i++) begin
      if (row_sel != 8'h00) chk("tear_next_frame_full", 32'(col_out), 32'hFF);
      tick();
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
